sha3_sequencer: RTL
===================

# sha3_sequencer

Controller that sequences the multi-cycle keccak core for a complete hash. On `start` it clears the core, streams `num_chunks` rate-sized chunks from a synchronous message ROM, giving each chunk exactly S enabled cycles. It then captures the digest and emits it as lowercase ASCII hex characters over a valid/ready byte handshake that feeds the UART transmitter. It sits between `sp_rom`, `keccak` and `uart_tx` in the SHA3 top level.

## Interface
- `D`, 512, digest width in bits; multiple of 4
- `S`, 4, core cycles per chunk; must be ≥ 2
- `CHUNK_W`, 5, width of chunk address/count
- `NEWLINE`, 1, when 1 append 0x0D, 0x0A after the hex digits
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle request to begin a hash
- `abort`  in  1  synchronous cancel of the current operation
- `num_chunks`  in  CHUNK_W  chunk count, sampled when `start` is accepted
- `chunk_addr`  out  CHUNK_W  message ROM address (1-cycle read latency)
- `core_reset`  out  1  active-high synchronous clear to keccak
- `core_enable`  out  1  keccak round enable
- `digest`  in  D  keccak digest output
- `char_data`  out  8  ASCII character
- `char_valid`  out  1  `char_data` valid
- `char_ready`  in  1  sink accepts the character on `char_valid & char_ready`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last character is transferred

## Operation
- States: IDLE, CLEAR, ABSORB, LATCH, EMIT.
- IDLE → CLEAR: on `start` with `num_chunks` ≠ 0.
  - Latch `num_chunks`; set `chunk_addr` to 0.
  - `start` with `num_chunks` = 0 is ignored.
  - `start` in any non-IDLE state is ignored.
- CLEAR: lasts one cycle; `core_reset` = 1 and `core_enable` = 0. → ABSORB.
- ABSORB:
  - `core_enable` = 1 throughout.
  - Cycle counter runs 0..S-1; chunk counter runs 0..N-1.
  - `chunk_addr` increments on the edge ending cycle S-2 of every chunk except the last. This prefetch makes the ROM output equal chunk k during all S cycles of chunk k.
  - After cycle S-1 of chunk N-1 → LATCH.
- LATCH: one cycle, `core_enable` = 0. `digest` is captured into an internal D-bit register. → EMIT.
- EMIT:
  - Characters are sent most-significant nibble first: nibble D/4-1 down to 0.
  - Nibble mapping: 0-9 → 0x30-0x39; a-f → 0x61-0x66.
  - If `NEWLINE` = 1, 0x0D then 0x0A follow the hex digits.
  - `char_data` is held stable while `char_valid` is high and `char_ready` is low.
  - The next character is presented in the cycle after a transfer; `char_valid` never drops between characters.
  - After the final transfer, `done` = 1 for one cycle → IDLE.
- `abort` has priority over every other transition in any non-IDLE state. Next state is IDLE; `core_reset` pulses for one cycle; `char_valid` and `core_enable` drop; `done` is not asserted.
- `chunk_addr` is held after the hash completes; it returns to 0 only on `start` or reset.

## Timing
- Reset values (asynchronous, all registered outputs): state IDLE, `chunk_addr` 0, `core_reset` 1, `core_enable` 0, `char_valid` 0, `char_data` 0x00, `busy` 0, `done` 0.
- First clock after reset release: `core_reset` = 0.
- `start` sampled at edge t0:
  - CLEAR occupies cycle t0+1.
  - ABSORB occupies t0+2 .. t0+1+S·N.
  - LATCH occupies t0+2+S·N.
  - The first `char_valid` appears at t0+3+S·N.
- `busy` rises in cycle t0+1. It falls in the cycle after `done`.
- With `char_ready` tied to 1, EMIT lasts D/4 + 2·NEWLINE cycles.
- Counter widths: cycle counter $clog2(S); character index $clog2(D/4+2). No wrap-around is permitted within one operation.
- Asserting `reset_n` low mid-operation forces reset values immediately and asynchronously. No partial output follows.

## Test plan
- Basic hash: D=512, S=4, `num_chunks`=2, behavioural core returning digest 0x0123…cdef repeated, `char_ready`=1.
  - Required: `core_enable` high exactly 8 cycles; `chunk_addr` changes 0→1 at cycle 3 of ABSORB.
  - Required: characters "0123456789abcdef"×8 then 0x0D, 0x0A; `done` 1 cycle; `busy` 0 afterwards.
- Back-pressure: toggle `char_ready` pseudo-randomly during EMIT.
  - Required: no character dropped or duplicated; `char_data` stable whenever valid and not ready; 130 transfers total.
- Chunk alignment: ROM model with 1-cycle latency and `num_chunks`=29.
  - Required: in every ABSORB cycle the ROM output equals chunk (cycle_index / S); last address presented is 28.
- Ignored starts:
  - `start` with `num_chunks`=0 → state stays IDLE, `busy` 0.
  - `start` pulsed during ABSORB → no restart; total enabled cycles stay S·N.
- Abort: assert `abort` at character 10 of EMIT.
  - Required: next cycle IDLE, `char_valid` 0, `core_reset` pulse 1 cycle, no `done`.
  - A following `start` runs a full, correct hash.
- Async reset: drop `reset_n` mid-ABSORB between clock edges.
  - Required: outputs take reset values before the next edge; after release `core_reset` clears in one cycle and a new hash completes correctly.

Source files
------------

// File: rtl/sha3_sequencer.sv
// sha3_sequencer
// Runs the keccak core through one complete hash and then streams the digest
// out as lowercase hex text. Message chunks come from a synchronous ROM with
// one cycle of read latency. Characters leave over a valid/ready byte channel
// that feeds the UART transmitter.
module sha3_sequencer #(
  parameter int D       = 512,  // digest width in bits, multiple of 4
  parameter int S       = 4,    // core cycles per chunk, >= 2
  parameter int CHUNK_W = 5,    // chunk address / count width
  parameter int NEWLINE = 1     // append CR LF after the hex digits
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CHUNK_W-1:0] num_chunks,
  output logic [CHUNK_W-1:0] chunk_addr,
  output logic               core_reset,
  output logic               core_enable,
  input  logic [D-1:0]       digest,
  output logic [7:0]         char_data,
  output logic               char_valid,
  input  logic               char_ready,
  output logic               busy,
  output logic               done
);

  localparam int NIB     = D / 4;
  localparam int N_CHARS = NIB + 2 * NEWLINE;
  localparam int CYC_W   = $clog2(S);
  localparam int IDX_W   = $clog2(NIB + 2);

  localparam logic [CYC_W-1:0] CYC_LAST     = CYC_W'(S - 1);
  localparam logic [CYC_W-1:0] CYC_PREFETCH = CYC_W'(S - 2);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_CHARS - 1);
  localparam logic [IDX_W-1:0] IDX_NIB_LAST = IDX_W'(NIB - 1);
  localparam logic [IDX_W-1:0] IDX_CR       = IDX_W'(NIB);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ABSORB,
    ST_LATCH,
    ST_EMIT
  } state_t;

  state_t state_reg, state_next;

  logic [CYC_W-1:0]   cyc_reg,         cyc_next;
  logic [CHUNK_W-1:0] chunk_reg,       chunk_next;
  logic [CHUNK_W-1:0] num_reg,         num_next;
  logic [IDX_W-1:0]   idx_reg,         idx_next;
  logic [D-1:0]       digest_reg,      digest_next;
  logic [CHUNK_W-1:0] chunk_addr_reg,  chunk_addr_next;
  logic               core_reset_reg,  core_reset_next;
  logic               core_enable_reg, core_enable_next;
  logic               char_valid_reg,  char_valid_next;
  logic [7:0]         char_data_reg,   char_data_next;
  logic               busy_reg,        busy_next;
  logic               done_reg,        done_next;

  logic               last_chunk;

  // Nibble-to-ASCII table: 0-9 map to '0'-'9', 10-15 map to 'a'-'f'.
  logic [7:0] hex_lut [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hex
      localparam logic [7:0] CHAR = (gi < 10) ? 8'(48 + gi) : 8'(87 + gi);
      assign hex_lut[gi] = CHAR;
    end
  endgenerate

  assign last_chunk = (chunk_reg == num_reg - CHUNK_W'(1));

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_next       = state_reg;
    cyc_next         = cyc_reg;
    chunk_next       = chunk_reg;
    num_next         = num_reg;
    idx_next         = idx_reg;
    digest_next      = digest_reg;
    chunk_addr_next  = chunk_addr_reg;
    core_reset_next  = 1'b0;
    core_enable_next = core_enable_reg;
    char_valid_next  = char_valid_reg;
    char_data_next   = char_data_reg;
    done_next        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A zero-length request has nothing to hash and is dropped.
        if (start && (num_chunks != '0)) begin
          state_next       = ST_CLEAR;
          num_next         = num_chunks;
          chunk_addr_next  = '0;
          core_reset_next  = 1'b1;
          core_enable_next = 1'b0;
        end
      end

      ST_CLEAR: begin
        state_next       = ST_ABSORB;
        cyc_next         = '0;
        chunk_next       = '0;
        core_enable_next = 1'b1;
      end

      ST_ABSORB: begin
        if (cyc_reg == CYC_LAST) begin
          cyc_next = '0;
          if (last_chunk) begin
            state_next       = ST_LATCH;
            core_enable_next = 1'b0;
          end else begin
            chunk_next = chunk_reg + CHUNK_W'(1);
          end
        end else begin
          cyc_next = cyc_reg + CYC_W'(1);
          // Advance the ROM address one cycle early so its registered output
          // already holds the next chunk on that chunk's first core cycle.
          if ((cyc_reg == CYC_PREFETCH) && !last_chunk) begin
            chunk_addr_next = chunk_addr_reg + CHUNK_W'(1);
          end
        end
      end

      ST_LATCH: begin
        // The core is idle this cycle, so its digest is stable to capture.
        state_next      = ST_EMIT;
        digest_next     = digest;
        idx_next        = '0;
        char_valid_next = 1'b1;
        char_data_next  = hex_lut[digest[D-1 -: 4]];
      end

      ST_EMIT: begin
        if (char_ready) begin
          if (idx_reg == IDX_LAST) begin
            state_next      = ST_IDLE;
            char_valid_next = 1'b0;
            done_next       = 1'b1;
          end else begin
            // The captured digest is shifted so its top nibble is always the
            // one being sent.
            idx_next    = idx_reg + IDX_W'(1);
            digest_next = digest_reg << 4;
            if (idx_reg < IDX_NIB_LAST) begin
              char_data_next = hex_lut[digest_reg[D-5 -: 4]];
            end else if (idx_reg == IDX_NIB_LAST) begin
              char_data_next = 8'h0D;
            end else if (idx_reg == IDX_CR) begin
              char_data_next = 8'h0A;
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Cancel wins over everything once an operation is under way.
    if (abort && (state_reg != ST_IDLE)) begin
      state_next       = ST_IDLE;
      core_reset_next  = 1'b1;
      core_enable_next = 1'b0;
      char_valid_next  = 1'b0;
      done_next        = 1'b0;
    end

    // busy covers the done cycle so it falls only after the completion pulse.
    busy_next = (state_next != ST_IDLE) || done_next;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Counters, captured digest and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_reg         <= '0;
      chunk_reg       <= '0;
      num_reg         <= '0;
      idx_reg         <= '0;
      digest_reg      <= '0;
      chunk_addr_reg  <= '0;
      core_reset_reg  <= 1'b1;
      core_enable_reg <= 1'b0;
      char_valid_reg  <= 1'b0;
      char_data_reg   <= 8'h00;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      cyc_reg         <= cyc_next;
      chunk_reg       <= chunk_next;
      num_reg         <= num_next;
      idx_reg         <= idx_next;
      digest_reg      <= digest_next;
      chunk_addr_reg  <= chunk_addr_next;
      core_reset_reg  <= core_reset_next;
      core_enable_reg <= core_enable_next;
      char_valid_reg  <= char_valid_next;
      char_data_reg   <= char_data_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  assign chunk_addr  = chunk_addr_reg;
  assign core_reset  = core_reset_reg;
  assign core_enable = core_enable_reg;
  assign char_valid  = char_valid_reg;
  assign char_data   = char_data_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule
